// File: rtl/knn_vote.sv
// knn_vote: majority-vote classifier behind the knn solver array.
// Scans each solver's HW_K neighbour slots, tallies one vote per label,
// then reports the winning class (lowest index on ties) with its vote count.
module knn_vote #(
    parameter int HW_K      = 10,
    parameter int N_SOLVERS = 10,
    parameter int LABEL_W   = 4,
    parameter int N_CLASSES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         RD_EN,
    output logic [15:0]                  SOLVER_SEL,
    output logic [15:0]                  SEL,
    input  logic [15:0]                  DATA_IN,
    output logic                         busy,
    output logic                         label_valid,
    output logic [LABEL_W-1:0]           label_out,
    output logic [$clog2(HW_K+1)-1:0]    label_votes,
    output logic [15:0]                  label_solver,
    output logic                         done,
    output logic                         oob
);

    localparam int VW = $clog2(HW_K + 1);
    localparam int CW = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        SCAN,
        EMIT
    } state_t;

    state_t state, state_nxt;

    logic [VW-1:0]      cnt [N_CLASSES];
    logic [CW-1:0]      cidx;
    logic [LABEL_W-1:0] best_lbl;
    logic [VW-1:0]      best_cnt;
    logic [LABEL_W-1:0] cand_lbl;
    logic [VW-1:0]      cand_cnt;

    logic [LABEL_W-1:0] label;
    logic               in_range;
    logic               last_slot;
    logic               last_class;
    logic               last_solver;
    logic               unused_data;

    assign label       = DATA_IN[LABEL_W-1:0];
    assign in_range    = 32'(label) < N_CLASSES;
    assign last_slot   = SEL == 16'(HW_K - 1);
    assign last_class  = cidx == CW'(N_CLASSES - 1);
    assign last_solver = SOLVER_SEL == 16'(N_SOLVERS - 1);
    assign unused_data = ^DATA_IN[15:LABEL_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: start only honoured from IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COUNT;
            COUNT:   if (last_slot) state_nxt = SCAN;
            SCAN:    if (last_class) state_nxt = EMIT;
            EMIT:    state_nxt = last_solver ? IDLE : COUNT;
            default: state_nxt = IDLE;
        endcase
    end

    // Status and strobe outputs decoded from state
    always_comb begin
        busy        = state != IDLE;
        RD_EN       = state != IDLE;
        label_valid = state == EMIT;
        done        = (state == EMIT) && last_solver;
    end

    // Running best for the class sweep; class 0 always seeds the best
    always_comb begin
        cand_lbl = best_lbl;
        cand_cnt = best_cnt;
        if (cidx == '0 || cnt[cidx] > best_cnt) begin
            cand_lbl = LABEL_W'(cidx);
            cand_cnt = cnt[cidx];
        end
    end

    // Per-class vote counters, cleared on scan start and after each emit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned c = 0; c < N_CLASSES; c++) cnt[c] <= '0;
        end else if ((state == IDLE && start) || state == EMIT) begin
            for (int unsigned c = 0; c < N_CLASSES; c++) cnt[c] <= '0;
        end else if (state == COUNT && in_range) begin
            for (int unsigned c = 0; c < N_CLASSES; c++) begin
                if (32'(label) == c) cnt[c] <= cnt[c] + VW'(1);
            end
        end
    end

    // Read-port indices, class sweep, result registers and sticky oob.
    // The result is latched on the final sweep cycle so it is already
    // stable during EMIT and holds until the next strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SOLVER_SEL   <= '0;
            SEL          <= '0;
            cidx         <= '0;
            best_lbl     <= '0;
            best_cnt     <= '0;
            label_out    <= '0;
            label_votes  <= '0;
            label_solver <= '0;
            oob          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        SOLVER_SEL <= '0;
                        SEL        <= '0;
                        oob        <= 1'b0;
                    end
                end
                COUNT: begin
                    if (!in_range) oob <= 1'b1;
                    if (!last_slot) SEL <= SEL + 16'd1;
                    cidx <= '0;
                end
                SCAN: begin
                    best_lbl <= cand_lbl;
                    best_cnt <= cand_cnt;
                    if (last_class) begin
                        label_out    <= cand_lbl;
                        label_votes  <= cand_cnt;
                        label_solver <= SOLVER_SEL;
                    end else begin
                        cidx <= cidx + CW'(1);
                    end
                end
                EMIT: begin
                    SEL <= '0;
                    if (last_solver) SOLVER_SEL <= '0;
                    else             SOLVER_SEL <= SOLVER_SEL + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: table-driven scans, reset abort,
// start-while-busy, back-to-back scans and randomized label sets.
module tb_knn_vote;

    localparam int K   = 4;
    localparam int NC  = 4;
    localparam int NS  = 3;
    localparam int LW  = 4;
    localparam int VW  = $clog2(K + 1);
    localparam int PER = K + NC + 1;
    localparam int TOT = NS * PER;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rd_en;
    logic [15:0]   solver_sel;
    logic [15:0]   sel;
    logic [15:0]   data_in;
    logic          busy;
    logic          label_valid;
    logic [LW-1:0] label_out;
    logic [VW-1:0] label_votes;
    logic [15:0]   label_solver;
    logic          done;
    logic          oob;

    knn_vote #(
        .HW_K(K),
        .N_SOLVERS(NS),
        .LABEL_W(LW),
        .N_CLASSES(NC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .RD_EN(rd_en),
        .SOLVER_SEL(solver_sel),
        .SEL(sel),
        .DATA_IN(data_in),
        .busy(busy),
        .label_valid(label_valid),
        .label_out(label_out),
        .label_votes(label_votes),
        .label_solver(label_solver),
        .done(done),
        .oob(oob)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lab [NS][K];
        int el  [NS];
        int ev  [NS];
        bit eo;
    } vec_t;

    int          cur_lab [NS][K];
    logic [11:0] junk    [NS][K];

    // knn read port model: combinational lookup, junk in the upper bits
    always_comb begin
        data_in = 16'hFFFF;
        if (solver_sel < 16'(NS) && sel < 16'(K))
            data_in = {junk[solver_sel[1:0]][sel[1:0]], cur_lab[solver_sel[1:0]][sel[1:0]][3:0]};
    end

    int checks = 0;
    int errors = 0;
    int h_lbl = 0, h_votes = 0, h_sol = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain vote histogram per solver, first maximum wins
    function automatic void model(inout vec_t v);
        v.eo = 1'b0;
        for (int s = 0; s < NS; s++) begin
            int votes [NC];
            int best;
            for (int c = 0; c < NC; c++) votes[c] = 0;
            for (int k = 0; k < K; k++) begin
                if (v.lab[s][k] < NC) votes[v.lab[s][k]]++;
                else v.eo = 1'b1;
            end
            best = 0;
            for (int c = 1; c < NC; c++) if (votes[c] > votes[best]) best = c;
            v.el[s] = best;
            v.ev[s] = votes[best];
        end
    endfunction

    // Full scan from a negedge in IDLE; checks every cycle against the timeline
    task automatic run_scan(input vec_t v, input int extra, input bit pulse_busy, input bit pulse_done);
        cur_lab = v.lab;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < K; k++) junk[s][k] = 12'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int t = 1; t <= TOT + extra; t++) begin
            bit act;
            int ph, s;
            @(negedge clk);
            act = t <= TOT;
            ph  = (t - 1) % PER;
            s   = act ? (t - 1) / PER : 0;
            chk("busy", int'(busy), int'(act));
            chk("RD_EN", int'(rd_en), int'(act));
            chk("label_valid", int'(label_valid), int'(act && ph == PER - 1));
            chk("done", int'(done), int'(t == TOT));
            chk("SOLVER_SEL", int'(solver_sel), s);
            if (!act) chk("SEL_idle", int'(sel), 0);
            else if (ph < K) chk("SEL", int'(sel), ph);
            if (t == 1) chk("oob_cleared", int'(oob), 0);
            if (!act) chk("oob", int'(oob), int'(v.eo));
            if (act && ph == PER - 1) begin
                h_lbl   = v.el[s];
                h_votes = v.ev[s];
                h_sol   = s;
            end
            chk("label_out", int'(label_out), h_lbl);
            chk("label_votes", int'(label_votes), h_votes);
            chk("label_solver", int'(label_solver), h_sol);
            start = (pulse_busy && t == 5) || (pulse_done && t == TOT);
        end
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_RD_EN"}, int'(rd_en), 0);
        chk({tag, "_label_valid"}, int'(label_valid), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_SOLVER_SEL"}, int'(solver_sel), 0);
        chk({tag, "_SEL"}, int'(sel), 0);
        chk({tag, "_label_out"}, int'(label_out), 0);
        chk({tag, "_label_votes"}, int'(label_votes), 0);
        chk({tag, "_label_solver"}, int'(label_solver), 0);
        chk({tag, "_oob"}, int'(oob), 0);
    endtask

    vec_t tbl [3];
    vec_t rv;

    initial begin
        // Hand-derived vectors
        tbl[0].lab = '{'{2, 2, 1, 3}, '{3, 1, 3, 1}, '{5, 5, 0, 7}};
        tbl[0].el  = '{2, 1, 0};
        tbl[0].ev  = '{2, 2, 1};
        tbl[0].eo  = 1'b1;
        tbl[1].lab = '{'{0, 0, 0, 0}, '{1, 1, 1, 1}, '{2, 2, 2, 2}};
        tbl[1].el  = '{0, 1, 2};
        tbl[1].ev  = '{4, 4, 4};
        tbl[1].eo  = 1'b0;
        tbl[2].lab = '{'{4, 5, 6, 7}, '{3, 3, 3, 2}, '{1, 2, 1, 2}};
        tbl[2].el  = '{0, 3, 1};
        tbl[2].ev  = '{0, 3, 2};
        tbl[2].eo  = 1'b1;
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < K; k++) begin
                cur_lab[s][k] = 0;
                junk[s][k]    = '0;
            end

        #2 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table: entry 0 ends in the first IDLE cycle so entry 1 is back-to-back;
        // entry 1 also pulses start mid-scan and on the done cycle.
        for (int i = 0; i < 3; i++)
            run_scan(tbl[i], (i == 0) ? 1 : 3, i == 1, i == 1);

        // Reset during the class sweep of solver 1
        cur_lab = tbl[0].lab;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (PER + K + 2) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        h_lbl = 0; h_votes = 0; h_sol = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 2 * PER; t++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(label_valid), 0);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        run_scan(tbl[0], 2, 1'b0, 1'b0);

        // Randomized label sets against the reference model
        for (int n = 0; n < 20; n++) begin
            for (int s = 0; s < NS; s++)
                for (int k = 0; k < K; k++) rv.lab[s][k] = int'($urandom_range(0, 5));
            model(rv);
            run_scan(rv, 1 + int'($urandom_range(0, 2)), n[0], n[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote classifier that sits directly downstream of the `knn` solver array. On `start` it walks every solver's HW_K neighbour slots through the `knn` read port (`SOLVER_SEL`/`SEL` → `DATA_OUT`) and tallies one vote per slot label. For each solver it then emits the winning class with its vote count, so software or a later stage reads one classification per test point instead of HW_K raw labels.

## Interface
- `HW_K`, 10: neighbour slots per solver; must match `knn`.
- `N_SOLVERS`, 10: number of solvers to scan; must match `knn`.
- `LABEL_W`, 4: label field width taken from `DATA_IN[LABEL_W-1:0]`.
- `N_CLASSES`, 16: number of valid classes, ≤ 2^LABEL_W.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request to begin a full scan; ignored while `busy`.
- `RD_EN` output 1: drives `knn` `DONE` (read mode); high whenever `busy`.
- `SOLVER_SEL` output 16: solver index to `knn`.
- `SEL` output 16: slot index to `knn`.
- `DATA_IN` input 16: `knn` `DATA_OUT`, combinational response to `SOLVER_SEL`/`SEL` in the same cycle.
- `busy` output 1: scan in progress.
- `label_valid` output 1: one-cycle strobe, result fields valid.
- `label_out` output LABEL_W: winning class.
- `label_votes` output clog2(HW_K+1): vote count of the winner.
- `label_solver` output 16: solver index the result belongs to.
- `done` output 1: one-cycle strobe on the final result.
- `oob` output 1: sticky; set when a label ≥ N_CLASSES was seen; cleared on `start`.

## Operation
- Per-class vote counters: N_CLASSES entries, each clog2(HW_K+1) bits.
- States:
  - IDLE → COUNT on `start`. `SOLVER_SEL`=0, `SEL`=0, counters cleared, `oob` cleared.
  - COUNT: each cycle, the counter for `DATA_IN[LABEL_W-1:0]` increments if the label is < N_CLASSES; otherwise the vote is dropped and `oob` is set. `SEL` increments. After the `SEL`=HW_K-1 cycle → SCAN.
  - SCAN: class index c runs 0..N_CLASSES-1, one per cycle. The running best is replaced only when count[c] > best. Ties therefore go to the lowest class index. Best is initialised to class 0 with count[0] at c=0. After c=N_CLASSES-1 → EMIT.
  - EMIT: for one cycle, `label_valid`=1 with `label_out`, `label_votes`, `label_solver`=`SOLVER_SEL`. Counters are cleared.
    - If `SOLVER_SEL`=N_SOLVERS-1: `done`=1 in the same cycle → IDLE.
    - Otherwise: `SOLVER_SEL`+1, `SEL`=0 → COUNT.
- If every label was out of range, the winner is class 0 with 0 votes and `label_valid` still fires.
- `SEL` and `SOLVER_SEL` hold 0 in IDLE.
- Result fields hold their last values between strobes.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- `rst` mid-scan aborts immediately. No `label_valid` or `done` is produced; a new `start` is required.
- Per solver: HW_K (COUNT) + N_CLASSES (SCAN) + 1 (EMIT) cycles.
- Timeline, with `start` sampled at edge 0:
  - COUNT occupies cycles 1..HW_K.
  - The first `label_valid` is high in cycle HW_K+N_CLASSES+1.
  - `done` is high in cycle N_SOLVERS·(HW_K+N_CLASSES+1).
- `busy` and `RD_EN` rise in cycle 1 and fall the cycle after `done`.
- `start` while `busy` has no effect. `start` in the same cycle as the `done` strobe is also ignored.
- Back-to-back scans are possible: `start` in the first IDLE cycle after `done`.

## Test plan
- Single solver majority: HW_K=4, N_CLASSES=4, N_SOLVERS=1, slots {2,2,1,3} → one `label_valid` with `label_out`=2, `label_votes`=2, `label_solver`=0, `done` in the same cycle at cycle 9.
- Tie break: slots {3,1,3,1} → `label_out`=1, `label_votes`=2.
- Out-of-range: slots {5,5,0,7} with N_CLASSES=4 → `label_out`=0, `label_votes`=1, `oob`=1. `oob` stays 1 until the next `start`, then clears.
- Multi-solver sweep: N_SOLVERS=3, solver s holds all slots = s → three strobes with `label_solver`=0,1,2, `label_out`=0,1,2, `label_votes`=4, spaced 9 cycles apart. `done` only on the third. `SEL` and `SOLVER_SEL` sequence checked every cycle.
- `start` while busy: pulse `start` in cycle 5 of a scan → result timing is unchanged and no second scan runs.
- Reset mid-scan: assert `rst` in the SCAN of solver 1 → all outputs 0 asynchronously and no strobe afterwards. A subsequent `start` gives correct results from solver 0.
